// File: rtl/rr_mux_arb.sv
// N:1 stream multiplexer with registered output, fixed-select or round-robin grant,
// and valid/ready handshakes on every input channel and on the single output.
module rr_mux_arb #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  output logic [NUM_CH-1:0]          in_ready,
  input  logic                       mode,
  input  logic [SEL_W-1:0]           sel,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [SEL_W-1:0]           out_ch,
  input  logic                       out_ready
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  outCh_q, outCh_d;
  logic [DATA_W-1:0] outData_q, outData_d;
  logic [SEL_W-1:0]  grantIdx;
  logic [SEL_W-1:0]  scanSel;
  logic              found;
  logic              loadEn;
  int                scanIdx;

  assign out_valid = (state_q == FULL);
  assign out_data  = outData_q;
  assign out_ch    = outCh_q;
  assign loadEn    = ~out_valid | out_ready;

  // Grant search; in round-robin mode the index wraps explicitly so NUM_CH need not be a power of 2.
  always_comb begin
    found    = 1'b0;
    grantIdx = '0;
    scanIdx  = 0;
    scanSel  = '0;
    if (rst_n && loadEn) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (mode) begin
          scanIdx = int'(ptr_q) + k;
          if (scanIdx >= NUM_CH) scanIdx = scanIdx - NUM_CH;
        end else begin
          scanIdx = k;
        end
        scanSel = SEL_W'(scanIdx);
        if (!found && in_valid[scanSel] && (mode || (scanSel == sel))) begin
          found    = 1'b1;
          grantIdx = scanSel;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = found && (grantIdx == SEL_W'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    outData_d = outData_q;
    outCh_d   = outCh_q;
    if (found) begin
      state_d   = FULL;
      outData_d = in_data[int'(grantIdx)*DATA_W +: DATA_W];
      outCh_d   = grantIdx;
      ptr_d     = (int'(grantIdx) == NUM_CH-1) ? '0 : grantIdx + SEL_W'(1);
    end else if (out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      ptr_q     <= '0;
      outData_q <= '0;
      outCh_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      outData_q <= outData_d;
      outCh_q   <= outCh_d;
    end
  end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Scoreboard bench for rr_mux_arb: a 4-channel instance and a 3-channel instance
// share clock and reset; expected words are queued at issue time and checked on output.
module tb_rr_mux_arb;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [3:0]  aValid;
  logic [31:0] aData;
  logic [3:0]  aReady;
  logic        aMode;
  logic [1:0]  aSel;
  logic        aOutValid;
  logic [7:0]  aOutData;
  logic [1:0]  aOutCh;
  logic        aOutReady;

  logic [2:0]  bValid;
  logic [23:0] bData;
  logic [2:0]  bReady;
  logic        bMode;
  logic [1:0]  bSel;
  logic        bOutValid;
  logic [7:0]  bOutData;
  logic [1:0]  bOutCh;
  logic        bOutReady;

  logic [11:0] qA[$];
  logic [11:0] qB[$];

  always #5 clk = ~clk;

  rr_mux_arb #(.NUM_CH(4), .DATA_W(8)) dutA (
    .clk(clk), .rst_n(rst_n), .in_valid(aValid), .in_data(aData), .in_ready(aReady),
    .mode(aMode), .sel(aSel), .out_valid(aOutValid), .out_data(aOutData),
    .out_ch(aOutCh), .out_ready(aOutReady)
  );

  rr_mux_arb #(.NUM_CH(3), .DATA_W(8)) dutB (
    .clk(clk), .rst_n(rst_n), .in_valid(bValid), .in_data(bData), .in_ready(bReady),
    .mode(bMode), .sel(bSel), .out_valid(bOutValid), .out_data(bOutData),
    .out_ch(bOutCh), .out_ready(bOutReady)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle on instance A: drive, check the grant, queue the word that should emerge.
  task automatic applyStimulusA(input logic [3:0] v, input logic m, input logic [1:0] s,
                                input logic ordy, input logic [3:0] expReady);
    aValid = v; aMode = m; aSel = s; aOutReady = ordy;
    @(negedge clk);
    checkOutput("aInReady", {28'd0, aReady}, {28'd0, expReady});
    for (int i = 0; i < 4; i++)
      if (expReady[i]) qA.push_back({4'(i), aData[i*8 +: 8]});
    @(posedge clk); #1;
  endtask

  task automatic applyStimulusB(input logic [2:0] v, input logic m, input logic [1:0] s,
                                input logic ordy, input logic [2:0] expReady);
    bValid = v; bMode = m; bSel = s; bOutReady = ordy;
    @(negedge clk);
    checkOutput("bInReady", {29'd0, bReady}, {29'd0, expReady});
    for (int i = 0; i < 3; i++)
      if (expReady[i]) qB.push_back({4'(i), bData[i*8 +: 8]});
    @(posedge clk); #1;
  endtask

  // Monitors pop one expected word each time a word is accepted downstream.
  always @(negedge clk) begin
    if (rst_n && aOutValid && aOutReady) begin
      if (qA.size() == 0) begin
        checkOutput("aUnexpectedWord", {22'd0, aOutCh, aOutData}, 32'hFFFF_FFFF);
      end else begin
        logic [11:0] e;
        e = qA.pop_front();
        checkOutput("aOutCh", {30'd0, aOutCh}, {28'd0, e[11:8]});
        checkOutput("aOutData", {24'd0, aOutData}, {24'd0, e[7:0]});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bOutValid && bOutReady) begin
      if (qB.size() == 0) begin
        checkOutput("bUnexpectedWord", {22'd0, bOutCh, bOutData}, 32'hFFFF_FFFF);
      end else begin
        logic [11:0] e;
        e = qB.pop_front();
        checkOutput("bOutCh", {30'd0, bOutCh}, {28'd0, e[11:8]});
        checkOutput("bOutData", {24'd0, bOutData}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    aValid = 4'b1111; aData = 32'h13121110; aMode = 1'b1; aSel = 2'd0; aOutReady = 1'b1;
    bValid = 3'b000;  bData = 24'h222120;   bMode = 1'b1; bSel = 2'd0; bOutReady = 1'b1;

    // Reset held for three edges with every channel requesting.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstOutValid", {31'd0, aOutValid}, 32'd0);
    checkOutput("rstOutData", {24'd0, aOutData}, 32'd0);
    checkOutput("rstOutCh", {30'd0, aOutCh}, 32'd0);
    @(negedge clk);
    checkOutput("rstInReady", {28'd0, aReady}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulusA(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001);

    // Fixed select.
    aData[23:16] = 8'hA5;
    applyStimulusA(4'b1111, 1'b0, 2'd2, 1'b1, 4'b0100);
    applyStimulusA(4'b1111, 1'b0, 2'd3, 1'b1, 4'b1000);
    aData[23:16] = 8'h12;

    // Round-robin with all channels busy, no bubbles.
    for (int r = 0; r < 8; r++) begin
      applyStimulusA(4'b1111, 1'b1, 2'd0, 1'b1, 4'(1 << (r % 4)));
      checkOutput("rrOutValid", {31'd0, aOutValid}, 32'd1);
    end

    // Sparse requests with wrap from pointer 3.
    applyStimulusA(4'b0100, 1'b1, 2'd0, 1'b1, 4'b0100);
    applyStimulusA(4'b0101, 1'b1, 2'd0, 1'b1, 4'b0001);
    applyStimulusA(4'b0101, 1'b1, 2'd0, 1'b1, 4'b0100);
    applyStimulusA(4'b0101, 1'b1, 2'd0, 1'b1, 4'b0001);

    // Backpressure holding a ch1 word.
    aData[15:8] = 8'h3C;
    applyStimulusA(4'b0010, 1'b1, 2'd0, 1'b1, 4'b0010);
    for (int r = 0; r < 5; r++) begin
      applyStimulusA(4'b1111, 1'b1, 2'd0, 1'b0, 4'b0000);
      checkOutput("stallData", {24'd0, aOutData}, 32'h3C);
      checkOutput("stallCh", {30'd0, aOutCh}, 32'd1);
    end
    applyStimulusA(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0100);
    checkOutput("releaseData", {24'd0, aOutData}, 32'h12);

    // Reset while a word is held.
    aData[31:24] = 8'h77;
    applyStimulusA(4'b1000, 1'b1, 2'd0, 1'b1, 4'b1000);
    applyStimulusA(4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000);
    checkOutput("heldData", {24'd0, aOutData}, 32'h77);
    rst_n = 1'b0;
    aValid = 4'b1111;
    @(negedge clk);
    checkOutput("midRstInReady", {28'd0, aReady}, 32'd0);
    @(posedge clk); #1;
    qA.delete();
    qB.delete();
    rst_n = 1'b1;
    aValid = 4'b0000;
    checkOutput("midRstOutValid", {31'd0, aOutValid}, 32'd0);
    checkOutput("midRstOutData", {24'd0, aOutData}, 32'd0);

    // Out-of-range select on the 3-channel instance grants nothing.
    applyStimulusB(3'b111, 1'b0, 2'd3, 1'b1, 3'b000);
    applyStimulusB(3'b111, 1'b0, 2'd3, 1'b1, 3'b000);
    checkOutput("badSelOutValid", {31'd0, bOutValid}, 32'd0);

    // Pointer restarted at channel 0 on both instances; 3-channel wrap.
    applyStimulusA(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001);
    aValid = 4'b0000;
    applyStimulusB(3'b111, 1'b1, 2'd0, 1'b1, 3'b001);
    applyStimulusB(3'b111, 1'b1, 2'd0, 1'b1, 3'b010);
    applyStimulusB(3'b111, 1'b1, 2'd0, 1'b1, 3'b100);
    applyStimulusB(3'b111, 1'b1, 2'd0, 1'b1, 3'b001);
    bValid = 3'b000;

    // Drain and confirm every expected word came out.
    aOutReady = 1'b1;
    bOutReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("aQueueEmpty", qA.size(), 32'd0);
    checkOutput("bQueueEmpty", qB.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
